// File: rtl/pipe_mem_pkg.sv
// Shared encodings for pipe_mem_arbiter and its optional fetch buffer.
package pipe_mem_pkg;

    localparam int DEF_AW = 32;
    localparam int DEF_DW = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_D  = 1'b1
    } gnt_e;

endpackage

// File: rtl/pipe_mem_ibuf.sv
// One-entry fetch buffer: tag/data/valid register with hit compare and store invalidate.
module pipe_mem_ibuf
    import pipe_mem_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [AW-1:0] load_tag,
    input  logic [DW-1:0] load_data,
    input  logic          inval,
    input  logic [AW-1:0] inval_addr,
    input  logic [AW-1:0] lookup_addr,
    output logic          hit,
    output logic [DW-1:0] data
);

    logic          valid_q, valid_d;
    logic [AW-1:0] tag_q, tag_d;
    logic [DW-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            tag_d   = load_tag;
            data_d  = load_data;
        end
        if (inval && (inval_addr == tag_q)) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
        end
    end

    assign hit  = valid_q && (lookup_addr == tag_q);
    assign data = data_q;

endmodule

// File: rtl/pipe_mem_arbiter.sv
// Shares one variable-latency memory between the fetch and data ports (req/ack, timeout).
// Define PIPE_MEM_ARBITER_IBUF_EN to serve repeated fetches from a one-entry buffer.
module pipe_mem_arbiter
    import pipe_mem_pkg::*;
#(
    parameter int AW       = DEF_AW,
    parameter int DW       = DEF_DW,
    parameter int WAIT_MAX = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ready,
    input  logic          d_re,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ready,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          bus_err,
    output logic          stall
);

    // state | meaning
    // IDLE  | no transaction; arbitrate the pending ports
    // BUSY  | mem_req held for the grantee, or a fetch-buffer hit being served
    // RESP  | grantee's ready pulse (with bus_err if the access timed out)

    // Timeout down-counter: loaded at grant, terminal count 0 ends the WAIT_MAX-th req cycle.
    localparam logic [7:0] WAIT_LOAD = 8'(WAIT_MAX - 1);

    state_e        state_q, state_d;
    gnt_e          gnt_q, gnt_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          if_ready_q, if_ready_d;
    logic          d_ready_q, d_ready_d;
    logic          bus_err_q, bus_err_d;
    logic          hit_q, hit_d;
    logic [7:0]    cnt_q, cnt_d;

    logic          d_pend, pick_d, ibuf_hit;
    logic [DW-1:0] ibuf_data;

    assign d_pend = d_re | d_we;
    assign pick_d = d_pend & (~if_req | (gnt_q == GNT_IF));

`ifdef PIPE_MEM_ARBITER_IBUF_EN
    logic ibuf_load, ibuf_inval;

    assign ibuf_load  = (state_q == BUSY) && !hit_q && mem_ack && (gnt_q == GNT_IF);
    assign ibuf_inval = (state_q == IDLE) && pick_d && d_we;

    pipe_mem_ibuf #(.AW(AW), .DW(DW)) u_ibuf (
        .clk         (clk),
        .rst         (rst),
        .load        (ibuf_load),
        .load_tag    (mem_addr_q),
        .load_data   (mem_rdata),
        .inval       (ibuf_inval),
        .inval_addr  (d_addr),
        .lookup_addr (if_addr),
        .hit         (ibuf_hit),
        .data        (ibuf_data)
    );
`else
    assign ibuf_hit  = 1'b0;
    assign ibuf_data = '0;
`endif

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_ready_d  = 1'b0;
        d_ready_d   = 1'b0;
        bus_err_d   = 1'b0;
        hit_d       = hit_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: begin
                hit_d = 1'b0;
                if (pick_d) begin
                    gnt_d       = GNT_D;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    cnt_d       = WAIT_LOAD;
                    state_d     = BUSY;
                end else if (if_req) begin
                    gnt_d       = GNT_IF;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                    cnt_d       = WAIT_LOAD;
                    state_d     = BUSY;
                    // A hit spends its BUSY cycle without touching memory, matching a zero-wait fetch.
                    if (ibuf_hit) begin
                        hit_d      = 1'b1;
                        if_rdata_d = ibuf_data;
                    end else begin
                        mem_req_d = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (hit_q) begin
                    hit_d      = 1'b0;
                    if_ready_d = 1'b1;
                    state_d    = RESP;
                end else if (mem_ack || (cnt_q == 8'd0)) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    bus_err_d = !mem_ack;
                    state_d   = RESP;
                    if (gnt_q == GNT_D) begin
                        d_ready_d = 1'b1;
                        d_rdata_d = (mem_ack && !mem_we_q) ? mem_rdata : '0;
                    end else begin
                        if_ready_d = 1'b1;
                        if_rdata_d = mem_ack ? mem_rdata : '0;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_q       <= GNT_IF;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_ready_q  <= 1'b0;
            d_ready_q   <= 1'b0;
            bus_err_q   <= 1'b0;
            hit_q       <= 1'b0;
            cnt_q       <= 8'd0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_ready_q  <= if_ready_d;
            d_ready_q   <= d_ready_d;
            bus_err_q   <= bus_err_d;
            hit_q       <= hit_d;
            cnt_q       <= cnt_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign if_ready  = if_ready_q;
    assign d_ready   = d_ready_q;
    assign bus_err   = bus_err_q;
    assign stall     = (if_req & ~if_ready_q) | (d_pend & ~d_ready_q);

endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// Scoreboard bench for pipe_mem_arbiter; a second instance with WAIT_MAX=4 covers timeouts.
module tb_pipe_mem_arbiter;
    import pipe_mem_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        if_req, d_re, d_we, mem_ack;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic        if_ready, d_ready, mem_req, mem_we, bus_err, stall;

    logic        if_req_t, d_re_t, d_we_t, mem_ack_t;
    logic [31:0] if_addr_t, d_addr_t, d_wdata_t, mem_rdata_t;
    logic [31:0] if_rdata_t, d_rdata_t, mem_addr_t, mem_wdata_t;
    logic        if_ready_t, d_ready_t, mem_req_t, mem_we_t, bus_err_t, stall_t;

    pipe_mem_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .d_re(d_re), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .bus_err(bus_err), .stall(stall)
    );

    pipe_mem_arbiter #(.WAIT_MAX(4)) dut_t (
        .clk(clk), .rst(rst),
        .if_req(if_req_t), .if_addr(if_addr_t), .if_rdata(if_rdata_t), .if_ready(if_ready_t),
        .d_re(d_re_t), .d_we(d_we_t), .d_addr(d_addr_t), .d_wdata(d_wdata_t),
        .d_rdata(d_rdata_t), .d_ready(d_ready_t),
        .mem_req(mem_req_t), .mem_we(mem_we_t), .mem_addr(mem_addr_t), .mem_wdata(mem_wdata_t),
        .mem_rdata(mem_rdata_t), .mem_ack(mem_ack_t), .bus_err(bus_err_t), .stall(stall_t)
    );

`ifdef PIPE_MEM_ARBITER_IBUF_EN
    localparam bit IBUF = 1'b1;
`else
    localparam bit IBUF = 1'b0;
`endif

    typedef struct packed { logic who; logic [31:0] data; logic err; } rsp_t;
    typedef struct packed { logic we; logic [31:0] addr; logic [31:0] wdata; } req_t;

    rsp_t        rsp_q[$];
    req_t        req_q[$];
    rsp_t        rs;
    req_t        rq;
    logic [31:0] mem_model [logic [31:0]];
    logic [31:0] held_addr;
    int checks = 0, errors = 0;
    int ack_delay = 0, req_cyc = 0, last_req_len = 0, req_starts = 0, rsp_seen = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rd(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return a ^ 32'hA5A5_0000;
    endfunction

    // Memory responder plus request/response scoreboards, sampled on the falling edge.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mem_ack = 1'b0;
                req_cyc = 0;
            end else begin
                if (mem_req) begin
                    if (req_cyc == 0) begin
                        req_starts++;
                        held_addr = mem_addr;
                        if (req_q.size() == 0) begin
                            check("mem_req_unexpected", 32'(req_q.size()), 32'd1);
                        end else begin
                            rq = req_q.pop_front();
                            check("mem_we", 32'(mem_we), 32'(rq.we));
                            check("mem_addr", mem_addr, rq.addr);
                            if (rq.we) check("mem_wdata", mem_wdata, rq.wdata);
                        end
                    end else begin
                        check("mem_addr_stable", mem_addr, held_addr);
                    end
                    if (req_cyc == ack_delay) begin
                        mem_ack = 1'b1;
                        if (mem_we) begin
                            mem_model[mem_addr] = mem_wdata;
                            mem_rdata = 32'h0;
                        end else begin
                            mem_rdata = rd(mem_addr);
                        end
                    end else begin
                        mem_ack = 1'b0;
                    end
                    req_cyc++;
                end else begin
                    if (req_cyc != 0) last_req_len = req_cyc;
                    req_cyc = 0;
                    mem_ack = 1'b0;
                end
                if (if_ready || d_ready) begin
                    check("ready_exclusive", 32'(if_ready & d_ready), 32'd0);
                    if (rsp_q.size() == 0) begin
                        check("ready_unexpected", 32'(rsp_q.size()), 32'd1);
                    end else begin
                        rs = rsp_q.pop_front();
                        check("rsp_port", 32'(d_ready), 32'(rs.who));
                        check("rsp_data", d_ready ? d_rdata : if_rdata, rs.data);
                        check("rsp_bus_err", 32'(bus_err), 32'(rs.err));
                        rsp_seen++;
                    end
                end
            end
        end
    end

    task automatic wait_rsp(input int n, input int budget);
        int target;
        target = rsp_seen + n;
        for (int i = 0; i < budget && rsp_seen < target; i++) @(posedge clk);
        check("rsp_count", 32'(rsp_seen), 32'(target));
        #1;
    endtask

    task automatic fetch(input logic [31:0] a, input bit expect_mem);
        @(negedge clk);
        if_addr = a;
        if_req  = 1'b1;
        if (expect_mem) req_q.push_back('{1'b0, a, 32'h0});
        rsp_q.push_back('{1'b1 == 1'b0, rd(a), 1'b0});
        wait_rsp(1, 20);
        if_req = 1'b0;
    endtask

    task automatic data_op(input logic re, input logic we, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] exp_rd);
        @(negedge clk);
        d_re    = re;
        d_we    = we;
        d_addr  = a;
        d_wdata = wd;
        req_q.push_back('{we, a, wd});
        rsp_q.push_back('{1'b1, exp_rd, 1'b0});
        wait_rsp(1, 30);
        d_re = 1'b0;
        d_we = 1'b0;
    endtask

    task automatic t_load(input logic ack, input logic [31:0] rdat, output int n, output bit got);
        @(negedge clk);
        mem_ack_t   = ack;
        mem_rdata_t = rdat;
        d_addr_t    = 32'h100;
        d_re_t      = 1'b1;
        n   = 0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (mem_req_t) begin
                n++;
                check("t_mem_addr", mem_addr_t, 32'h100);
                check("t_stall", 32'(stall_t), 32'd1);
            end
            if (d_ready_t) got = 1'b1;
        end
    endtask

    initial begin
        int  s, n;
        bit  got;
        rst = 1'b1;
        if_req = 1'b0; d_re = 1'b0; d_we = 1'b0;
        if_addr = '0; d_addr = '0; d_wdata = '0;
        if_req_t = 1'b0; d_re_t = 1'b0; d_we_t = 1'b0; mem_ack_t = 1'b0;
        if_addr_t = '0; d_addr_t = '0; d_wdata_t = '0; mem_rdata_t = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_readies", {30'd0, if_ready, d_ready}, 32'd0);
        check("rst_rdata", if_rdata | d_rdata, 32'd0);
        check("rst_bus_err", 32'(bus_err), 32'd0);
        rst = 1'b0;

        // single fetch, ack in first req cycle
        mem_model[32'h4] = 32'h8C01_0000;
        @(negedge clk);
        if_addr = 32'h4;
        if_req  = 1'b1;
        req_q.push_back('{1'b0, 32'h4, 32'h0});
        rsp_q.push_back('{1'b0, 32'h8C01_0000, 1'b0});
        #1 check("stall_fetch_pending", 32'(stall), 32'd1);
        wait_rsp(1, 20);
        check("fetch_req_len", 32'(last_req_len), 32'd1);
        check("fetch_if_rdata", if_rdata, 32'h8C01_0000);
        if_req = 1'b0;
        #1 check("stall_idle", 32'(stall), 32'd0);

        // simultaneous fetch and store, requests held: D, IF, D, IF, D
        @(negedge clk);
        if_addr = 32'h8;  if_req = 1'b1;
        d_addr  = 32'h10; d_wdata = 32'hDEAD_BEEF; d_we = 1'b1;
        req_q.push_back('{1'b1, 32'h10, 32'hDEAD_BEEF});
        req_q.push_back('{1'b0, 32'h8, 32'h0});
        req_q.push_back('{1'b1, 32'h10, 32'hDEAD_BEEF});
        if (!IBUF) req_q.push_back('{1'b0, 32'h8, 32'h0});
        req_q.push_back('{1'b1, 32'h10, 32'hDEAD_BEEF});
        rsp_q.push_back('{1'b1, 32'h0, 1'b0});
        rsp_q.push_back('{1'b0, rd(32'h8), 1'b0});
        rsp_q.push_back('{1'b1, 32'h0, 1'b0});
        rsp_q.push_back('{1'b0, rd(32'h8), 1'b0});
        rsp_q.push_back('{1'b1, 32'h0, 1'b0});
        #1 check("stall_both_pending", 32'(stall), 32'd1);
        wait_rsp(5, 40);
        if_req = 1'b0;
        d_we   = 1'b0;
        check("arb_req_drain", 32'(req_q.size()), 32'd0);

        // load with ack delayed 5 cycles
        ack_delay = 5;
        mem_model[32'h40] = 32'h1234_5678;
        data_op(1'b1, 1'b0, 32'h40, 32'h0, 32'h1234_5678);
        ack_delay = 0;
        check("load_req_len", 32'(last_req_len), 32'd6);
        check("load_d_rdata", d_rdata, 32'h1234_5678);
        check("if_rdata_hold", if_rdata, rd(32'h8));

        // d_re and d_we together behave as a store
        data_op(1'b1, 1'b1, 32'h44, 32'hCAFE_F00D, 32'h0);
        data_op(1'b1, 1'b0, 32'h44, 32'h0, 32'hCAFE_F00D);

        // reset during the second BUSY cycle
        ack_delay = 10;
        @(negedge clk);
        d_addr = 32'h80;
        d_re   = 1'b1;
        req_q.push_back('{1'b0, 32'h80, 32'h0});
        @(posedge clk);
        @(posedge clk);
        #1 check("busy_before_rst", 32'(mem_req), 32'd1);
        rst  = 1'b1;
        d_re = 1'b0;
        @(posedge clk);
        #1;
        check("rst_abort_mem_req", 32'(mem_req), 32'd0);
        check("rst_abort_readies", {30'd0, if_ready, d_ready}, 32'd0);
        rst = 1'b0;
        ack_delay = 0;
        fetch(32'h4, 1'b1);
        check("post_rst_fetch_len", 32'(last_req_len), 32'd1);

        // fetch buffer: repeat hit, then store invalidates
        fetch(32'h20, 1'b1);
        s = req_starts;
        fetch(32'h20, !IBUF);
        check("repeat_fetch_mem_reqs", 32'(req_starts - s), IBUF ? 32'd0 : 32'd1);
        data_op(1'b0, 1'b1, 32'h20, 32'h1111_2222, 32'h0);
        s = req_starts;
        fetch(32'h20, 1'b1);
        check("fetch_after_store_reqs", 32'(req_starts - s), 32'd1);
        check("fetch_after_store_data", if_rdata, 32'h1111_2222);

        // WAIT_MAX=4 instance: good load, timeout, good load
        t_load(1'b1, 32'h55AA, n, got);
        check("t_ok_ready", 32'(got), 32'd1);
        check("t_ok_len", 32'(n), 32'd1);
        check("t_ok_bus_err", 32'(bus_err_t), 32'd0);
        check("t_ok_rdata", d_rdata_t, 32'h55AA);
        @(posedge clk);
        #1 d_re_t = 1'b0;

        t_load(1'b0, 32'h0, n, got);
        check("t_to_ready", 32'(got), 32'd1);
        check("t_to_len", 32'(n), 32'd4);
        check("t_to_bus_err", 32'(bus_err_t), 32'd1);
        check("t_to_rdata", d_rdata_t, 32'h0);
        check("t_to_mem_req", 32'(mem_req_t), 32'd0);
        check("t_to_if_side", {31'd0, if_ready_t} | if_rdata_t, 32'd0);
        check("t_to_mem_wr", {31'd0, mem_we_t} | mem_wdata_t, 32'd0);
        @(posedge clk);
        #1 d_re_t = 1'b0;

        t_load(1'b1, 32'h77, n, got);
        check("t_recover_ready", 32'(got), 32'd1);
        check("t_recover_bus_err", 32'(bus_err_t), 32'd0);
        check("t_recover_rdata", d_rdata_t, 32'h77);
        @(posedge clk);
        #1 d_re_t = 1'b0;

        check("rsp_queue_drain", 32'(rsp_q.size()), 32'd0);
        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before 500000");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pipe_mem_arbiter.md
Name: pipe_mem_arbiter

Overview:
- Shares one single-port, variable-latency unified memory between the pipelined CPU's instruction-fetch port and its data port.
- Arbitrates between the two ports and sequences each memory transaction with a req/ack handshake.
- Returns read data to the requesting port with a one-cycle ready pulse.
- Drives the `stall` signal that the pipeline feeds into its PC/IR write-enable logic.
- Sits between the CPU core and the memory subsystem.

Parameters:
- AW, 32, address width in bits.
- DW, 32, data width in bits.
- WAIT_MAX, 255, number of cycles `mem_req` may stay high without `mem_ack` before the transaction aborts. Range 1..255.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- if_req  in  1  instruction fetch request; held high until `if_ready`.
- if_addr  in  AW  fetch address (PC).
- if_rdata  out  DW  fetched instruction; valid while `if_ready` is high.
- if_ready  out  1  one-cycle completion pulse for the fetch port.
- d_re  in  1  data read request (load); held until `d_ready`.
- d_we  in  1  data write request (store); held until `d_ready`.
- d_addr  in  AW  data address (ALU output).
- d_wdata  in  DW  store data.
- d_rdata  out  DW  load data; valid while `d_ready` is high.
- d_ready  out  1  one-cycle completion pulse for the data port.
- mem_req  out  1  memory request; held high until `mem_ack`.
- mem_we  out  1  memory write strobe; qualified by `mem_req`.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data; sampled in the `mem_ack` cycle.
- mem_ack  in  1  memory completion; may be asserted in the first `mem_req` cycle.
- bus_err  out  1  one-cycle pulse, coincident with the ready pulse, when a transaction timed out.
- stall  out  1  pipeline stall, combinational.

Behaviour:
- Reset (synchronous): state = IDLE. All of the following clear to 0: `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `if_ready`, `d_ready`, `if_rdata`, `d_rdata`, `bus_err`, last-grant flag (0 = IF), wait counter.
- Reset mid-transaction abandons the transaction; `mem_req` is low from the next cycle.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - The data port is pending when `d_re | d_we`.
  - If only one port is pending, that port is granted.
  - If both are pending, the data port wins unless the last grant was data, in which case IF wins (alternating; no starvation).
  - On grant, register `mem_addr`, `mem_we` (= `d_we` for the data port, 0 for IF) and `mem_wdata`; set `mem_req` = 1; record the grantee; clear the wait counter; go to BUSY.
- BUSY:
  - `mem_req` stays high and all `mem_*` outputs stay stable. Port inputs are ignored.
  - On `mem_ack`: capture `mem_rdata` into the grantee's rdata register (rdata is 0 for writes); `mem_req` ← 0; go to RESP.
  - Otherwise the counter increments. When it reaches WAIT_MAX: `mem_req` ← 0, rdata ← 0, `bus_err` is flagged, go to RESP.
- RESP:
  - The grantee's ready is high for exactly this cycle, and `bus_err` is high if flagged.
  - Next state is IDLE.
  - Requests are not re-granted in RESP, because the requester still holds its request during the ready cycle.
- Minimum latency: request seen at edge N, `mem_req` high in cycle N+1, `mem_ack` in N+1, ready in cycle N+2. A fetch therefore costs at least 3 cycles.
- `if_rdata` and `d_rdata` hold their last captured value until overwritten.
- Stall: `stall` = (`if_req` & ~`if_ready`) | ((`d_re` | `d_we`) & ~`d_ready`).
- `d_re` and `d_we` asserted together is illegal; it is treated as a write.
- Address/data widths pass through unchanged; there is no alignment checking.

Optional Feature:
- Macro: `PIPE_MEM_ARBITER_IBUF_EN`.
- With the macro defined, a one-entry fetch buffer (tag, data, valid) is added:
  - A completed, non-error IF transaction loads the buffer.
  - In IDLE, an `if_req` whose `if_addr` equals the tag, with valid set, is served without a memory access: `if_rdata` ← buffer data, then RESP, so `if_ready` arrives in cycle N+2 with `mem_req` never asserted.
  - A granted data write whose `mem_addr` equals the tag clears valid.
  - Reset clears valid.
  - The buffer hit is considered only when the data port is not chosen by arbitration.
- Without the macro, every fetch goes to memory.

Decomposition:
- Shared package `pipe_mem_pkg`: state encoding (IDLE=2'd0, BUSY=2'd1, RESP=2'd2), grantee encoding (GNT_IF=1'b0, GNT_D=1'b1), default AW/DW.
- One sub-module, `pipe_mem_ibuf` (tag/data/valid register, hit compare, invalidate). It is instantiated only under the macro.

Test Plan:
- Fetch only, `if_addr`=0x00000004, `mem_ack` in the first `mem_req` cycle, `mem_rdata`=0x8C010000 → `mem_req` high exactly 1 cycle; `if_ready` 1 cycle later with `if_rdata`=0x8C010000; `stall`=1 until `if_ready`.
- `if_req` and `d_we` raised in the same cycle, `d_addr`=0x10, `d_wdata`=0xDEADBEEF, last grant IF → memory sees the write first (`mem_we`=1, `mem_addr`=0x10); then the fetch; then, with requests held, the grant order alternates D, IF, D.
- Load with `mem_ack` delayed 5 cycles, `mem_rdata`=0x12345678 → `mem_addr` stable for all 6 `mem_req` cycles; `d_ready` for 1 cycle with `d_rdata`=0x12345678.
- WAIT_MAX=4, `mem_ack` never asserted → `mem_req` drops after 4 cycles; `d_ready`=1, `bus_err`=1, `d_rdata`=0; FSM returns to IDLE.
- `rst` asserted in the second BUSY cycle → next cycle `mem_req`=0 and both ready outputs =0; a new `if_req` after reset is granted normally.
- Macro defined: fetch 0x20 twice → the second fetch has no `mem_req`; then store to 0x20 and fetch 0x20 → the fetch goes to memory.
